imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction memory writer: accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, and writes them into the byte-addressed instruction memory window starting at 0xBFC00000. It holds the CPU core in reset while loading and releases it once the image is in place. It is the write-side counterpart of the instruction fetch path, which reads 4 bytes at a time with byte a+0 in bits [7:0].

## Interface
- ADDR_W, 32, address and length width
- BASE_ADDR, 32'hBFC00000, byte address of the first loaded byte
- DEPTH, 4096, instruction memory size in bytes (multiple of 4)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  begin a load (sampled only in IDLE, DONE, ERR)
- len_i  in  ADDR_W  image length in bytes, sampled with start_i
- byte_valid_i  in  1  byte_i holds a valid byte
- byte_i  in  8  stream byte
- byte_ready_o  out  1  loader can accept a byte this cycle
- we_o  out  1  one-cycle word write strobe to instruction memory
- waddr_o  out  ADDR_W  word-aligned byte address of the write
- wdata_o  out  32  written word, little-endian packed
- cpu_rst_o  out  1  reset to the CPU core; high = hold
- busy_o  out  1  load in progress
- done_o  out  1  image loaded successfully
- err_o  out  1  load rejected or failed

## Operation
- States: IDLE, RECV, WRITE, (CSUM), DONE, ERR.
- IDLE: cpu_rst_o=1, no accepts. On start_i: latch len. len=0 -> DONE; len>DEPTH -> ERR; else clear byte counter and word buffer -> RECV.
- RECV: byte_ready_o=1. A byte transfers when byte_valid_i && byte_ready_o. Byte k is placed in wdata bits [8*(k%4)+7 : 8*(k%4)]. Counter increments per transfer. Lane 3 accepted, or byte len-1 accepted -> WRITE.
- WRITE: we_o=1 for exactly one cycle; waddr_o = BASE_ADDR + 4*(k/4); unfilled lanes of a partial last word are 0x00. Bytes remain -> RECV with buffer cleared; else -> DONE (or CSUM when enabled).
- DONE: done_o=1, cpu_rst_o=0. On start_i -> reload as from IDLE; cpu_rst_o rises the same cycle the state leaves DONE.
- ERR: err_o=1, cpu_rst_o=1, no writes. Leaves only on start_i, handled as in IDLE.
- start_i is ignored in RECV/WRITE/CSUM. byte_valid_i outside RECV/CSUM is ignored and never consumed.
- Address arithmetic is ADDR_W-bit unsigned, and the len>DEPTH check keeps every write inside [BASE_ADDR, BASE_ADDR+DEPTH-1].

## Timing
- Reset values: byte_ready_o=0, we_o=0, waddr_o=0, wdata_o=0, cpu_rst_o=1, busy_o=0, done_o=0, err_o=0; state IDLE.
- Reset mid-load aborts immediately, with no further we_o. Already-written memory words are not reverted.
- busy_o=1 in RECV, WRITE, CSUM.
- start_i at edge n leads to byte_ready_o=1 from cycle n+1.
- The 4th byte of a word accepted at edge n leads to we_o=1 in cycle n+1 with byte_ready_o=0; byte_ready_o=1 again in cycle n+2. Peak throughput is 4 bytes per 5 cycles.
- done_o/cpu_rst_o=0 start the cycle after the final WRITE cycle.
- waddr_o and wdata_o are valid only while we_o=1. Outside WRITE they hold their last value.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: an 8-bit running sum of all image bytes is kept. After the final WRITE, the loader enters CSUM with byte_ready_o=1 and accepts exactly one extra byte. If (sum + byte) mod 256 == 0, the next state is DONE; otherwise ERR. The checksum byte is never written. For len=0, CSUM is still entered.
- Not defined: no CSUM state and no sum register; the final WRITE goes directly to DONE.

## Test plan
- Reset: assert rst_i 2 cycles -> all outputs at reset values, cpu_rst_o=1, byte_ready_o=0.
- len=8, bytes 13 00 00 00 93 00 10 00, valid held high -> writes 0xBFC00000=0x00000013 and 0xBFC00004=0x00100093, each one cycle. done_o=1 and cpu_rst_o=0 the cycle after the second write.
- len=5, bytes 01 02 03 04 AA with random byte_valid_i gaps -> writes 0x04030201 at 0xBFC00000 and 0x000000AA at 0xBFC00004. Exactly 5 transfers.
- len=4097 -> err_o=1 next cycle, no we_o, cpu_rst_o=1. Then start_i with len=4 -> normal load, err_o=0.
- rst_i during RECV after 2 bytes -> no write, state IDLE. A following 4-byte load writes the correct word at 0xBFC00000.
- With IMEM_LOADER_CHECKSUM_EN: len=4, bytes 01 02 03 04 then 0xF6 -> done_o=1. Checksum 0xF7 -> err_o=1, and the word is still written.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the boot loader: the source drives valid/byte,
// and the loader answers with ready.
interface imem_loader_if;
    logic       byte_valid_i;
    logic [7:0] byte_i;
    logic       byte_ready_o;

    modport master (
        output byte_valid_i,
        output byte_i,
        input  byte_ready_o
    );

    modport slave (
        input  byte_valid_i,
        input  byte_i,
        output byte_ready_o
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: packs a byte stream little-endian into words,
// writes them from BASE_ADDR upward, and holds the CPU in reset until the image is in.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = 32'hBFC00000,
    parameter int unsigned          DEPTH     = 4096
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  len_i,
    imem_loader_if.slave       stream,
    output logic               we_o,
    output logic [ADDR_W-1:0]  waddr_o,
    output logic [31:0]        wdata_o,
    output logic               cpu_rst_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM  = 3'd5,
`endif
        S_ERR   = 3'd4
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    state_t             launch_state;
    logic [ADDR_W-1:0]  len_reg;
    logic [ADDR_W-1:0]  cnt_reg;
    logic [31:0]        buf_reg;
    logic [31:0]        buf_next;
    logic [ADDR_W-1:0]  waddr_reg;
    logic [31:0]        wdata_reg;
    logic               byte_ready;
    logic               xfer;
    logic [1:0]         lane;
    logic               last_byte;
    logic               word_full;
    logic               can_start;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         sum_reg;
`endif

    assign xfer      = byte_ready && stream.byte_valid_i;
    assign lane      = cnt_reg[1:0];
    assign last_byte = (cnt_reg + ADDR_W'(1)) == len_reg;
    assign word_full = (lane == 2'd3) || last_byte;
    assign can_start = start_i &&
                       (state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_ERR);

    // Incoming byte lands in its lane; untouched lanes keep the buffer (zero for new words).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign buf_next[8*gi +: 8] = (xfer && lane == 2'(gi)) ? stream.byte_i
                                                                    : buf_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        launch_state = S_RECV;
        if (len_i == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            launch_state = S_CSUM;
`else
            launch_state = S_DONE;
`endif
        end else if (len_i > DEPTH_L) begin
            launch_state = S_ERR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_next = launch_state;
                end
            end
            S_RECV: begin
                if (xfer && word_full) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt_reg < len_reg) begin
                    state_next = S_RECV;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = S_CSUM;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_next = ((sum_reg + stream.byte_i) == 8'h00) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        we_o       = 1'b0;
        cpu_rst_o  = 1'b1;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        case (state_reg)
            S_RECV: begin
                byte_ready = 1'b1;
                busy_o     = 1'b1;
            end
            S_WRITE: begin
                we_o   = 1'b1;
                busy_o = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                byte_ready = 1'b1;
                busy_o     = 1'b1;
            end
`endif
            S_DONE: begin
                done_o    = 1'b1;
                cpu_rst_o = 1'b0;
            end
            S_ERR:   err_o = 1'b1;
            default: ;
        endcase
    end

    // Write address/data are captured only when a word completes, so they hold
    // steady outside the write cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_reg   <= '0;
            cnt_reg   <= '0;
            buf_reg   <= '0;
            waddr_reg <= '0;
            wdata_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg   <= '0;
`endif
        end else begin
            if (can_start) begin
                len_reg <= len_i;
                cnt_reg <= '0;
                buf_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_reg <= '0;
`endif
            end
            if (state_reg == S_RECV && xfer) begin
                cnt_reg <= cnt_reg + ADDR_W'(1);
                buf_reg <= buf_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_reg <= sum_reg + stream.byte_i;
`endif
                if (word_full) begin
                    wdata_reg <= buf_next;
                    waddr_reg <= BASE_ADDR + {cnt_reg[ADDR_W-1:2], 2'b00};
                end
            end
            if (state_reg == S_WRITE) begin
                buf_reg <= '0;
            end
        end
    end

    assign stream.byte_ready_o = byte_ready;
    assign waddr_o             = waddr_reg;
    assign wdata_o             = wdata_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: one line per checked transaction,
// expected words/addresses computed by hand from the stimulus bytes.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] len_in;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader_if bus ();

    imem_loader dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .len_i     (len_in),
        .stream    (bus.slave),
        .we_o      (we),
        .waddr_o   (waddr),
        .wdata_o   (wdata),
        .cpu_rst_o (cpu_rst),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          xfers = 0;
    int          done_cyc = 0;
    logic        ready_after_start;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic [7:0]  img[0:15];
    logic [7:0]  stream[0:16];

    always @(posedge clk) begin
        if (we) begin
            wr_addr.push_back(waddr);
            wr_data.push_back(wdata);
            wr_cyc.push_back(cyc);
            $display("write  addr=0x%08h data=0x%08h cycle=%0d", waddr, wdata, cyc);
        end
        if (bus.byte_valid_i && bus.byte_ready_o) xfers++;
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        xfers = 0;
    endtask

    task automatic send_stream(input int n, input bit gaps);
        int i = 0;
        int g = 0;
        while (i < n && g < 400) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.byte_valid_i = 1'b0;
            end else begin
                bus.byte_valid_i = 1'b1;
                bus.byte_i       = stream[i];
                if (bus.byte_ready_o) i++;
            end
            @(negedge clk);
            g++;
        end
        bus.byte_valid_i = 1'b0;
        check("stream_sent", i, n);
    endtask

    task automatic run_load(input int len, input bit gaps, input bit auto_csum,
                            input logic [7:0] csum);
        logic [7:0] s = 8'h00;
        logic [7:0] cbyte;
        int n;
        clear_log();
        for (int i = 0; i < len; i++) begin
            stream[i] = img[i];
            s = s + img[i];
        end
        cbyte = auto_csum ? (8'h00 - s) : csum;
        n = len;
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream[len] = cbyte;
        n = len + 1;
`endif
        start  = 1'b1;
        len_in = len;
        @(negedge clk);
        start = 1'b0;
        ready_after_start = bus.byte_ready_o;
        send_stream(n, gaps);
        for (int g = 0; g < 60; g++) begin
            if (done || err) break;
            @(negedge clk);
        end
        done_cyc = cyc;
        $display("load   len=%0d transfers=%0d writes=%0d done=%0b err=%0b",
                 len, xfers, wr_addr.size(), done, err);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        len_in = '0;
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = 8'h00;

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready",   bus.byte_ready_o, 0);
        check("rst_we",      we, 0);
        check("rst_waddr",   waddr, 0);
        check("rst_wdata",   wdata, 0);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        check("rst_err",     err, 0);
        @(negedge clk);

        // Two full words, valid held high
        img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
        img[4] = 8'h93; img[5] = 8'h00; img[6] = 8'h10; img[7] = 8'h00;
        run_load(8, 1'b0, 1'b1, 8'h00);
        check("l8_ready_after_start", ready_after_start, 1);
        check("l8_nwrites", wr_addr.size(), 2);
        check("l8_addr0", wr_addr[0], 32'hBFC00000);
        check("l8_data0", wr_data[0], 32'h00000013);
        check("l8_addr1", wr_addr[1], 32'hBFC00004);
        check("l8_data1", wr_data[1], 32'h00100093);
        check("l8_write_spacing", wr_cyc[1] - wr_cyc[0], 5);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("l8_done_timing", done_cyc, wr_cyc[1] + 1);
`endif
        check("l8_done", done, 1);
        check("l8_cpu_rst", cpu_rst, 0);
        check("l8_busy", busy, 0);

        // Partial last word with random valid gaps
        img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04; img[4] = 8'hAA;
        run_load(5, 1'b1, 1'b1, 8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("l5_transfers", xfers, 6);
`else
        check("l5_transfers", xfers, 5);
`endif
        check("l5_nwrites", wr_addr.size(), 2);
        check("l5_addr0", wr_addr[0], 32'hBFC00000);
        check("l5_data0", wr_data[0], 32'h04030201);
        check("l5_addr1", wr_addr[1], 32'hBFC00004);
        check("l5_data1", wr_data[1], 32'h000000AA);
        check("l5_done", done, 1);

        // Oversized image rejected
        clear_log();
        start  = 1'b1;
        len_in = 32'd4097;
        @(negedge clk);
        start = 1'b0;
        check("big_err", err, 1);
        check("big_cpu_rst", cpu_rst, 1);
        check("big_busy", busy, 0);
        check("big_ready", bus.byte_ready_o, 0);
        repeat (3) @(negedge clk);
        check("big_no_write", wr_addr.size(), 0);
        check("big_err_held", err, 1);
        $display("reject len=4097 err=%0b writes=%0d", err, wr_addr.size());

        // Recovery from ERR with a normal load
        img[0] = 8'h6F; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
        run_load(4, 1'b0, 1'b1, 8'h00);
        check("rec_err", err, 0);
        check("rec_done", done, 1);
        check("rec_nwrites", wr_addr.size(), 1);
        check("rec_data", wr_data[0], 32'h0000006F);

        // Reset in the middle of a word
        clear_log();
        stream[0] = 8'h55; stream[1] = 8'h66;
        start  = 1'b1;
        len_in = 32'd4;
        @(negedge clk);
        start = 1'b0;
        send_stream(2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_write", wr_addr.size(), 0);
        check("abort_busy", busy, 0);
        check("abort_ready", bus.byte_ready_o, 0);
        check("abort_cpu_rst", cpu_rst, 1);
        check("abort_done", done, 0);
        $display("abort  after 2 bytes writes=%0d busy=%0b", wr_addr.size(), busy);
        img[0] = 8'hDE; img[1] = 8'hAD; img[2] = 8'hBE; img[3] = 8'hEF;
        run_load(4, 1'b0, 1'b1, 8'h00);
        check("post_abort_nwrites", wr_addr.size(), 1);
        check("post_abort_addr", wr_addr[0], 32'hBFC00000);
        check("post_abort_data", wr_data[0], 32'hEFBEADDE);
        check("post_abort_done", done, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum accepted and rejected
        img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04;
        run_load(4, 1'b0, 1'b0, 8'hF6);
        check("csum_ok_done", done, 1);
        check("csum_ok_err", err, 0);
        check("csum_ok_data", wr_data[0], 32'h04030201);
        run_load(4, 1'b0, 1'b0, 8'hF7);
        check("csum_bad_err", err, 1);
        check("csum_bad_done", done, 0);
        check("csum_bad_nwrites", wr_addr.size(), 1);
        check("csum_bad_data", wr_data[0], 32'h04030201);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
